// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-flow sequencer: flow-op codes, FSM states, default widths.
package pc_seq_pkg;

    localparam int PC_WIDTH_DEF    = 12;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int PC_STEP_DEF     = 2;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_B    = 4'd1;
    localparam logic [3:0] BR_BZ   = 4'd2;
    localparam logic [3:0] BR_BNZ  = 4'd3;
    localparam logic [3:0] BR_BGZ  = 4'd4;
    localparam logic [3:0] BR_BGEZ = 4'd5;
    localparam logic [3:0] BR_BLZ  = 4'd6;
    localparam logic [3:0] BR_BLEZ = 4'd7;
    localparam logic [3:0] BR_BV   = 4'd8;
    localparam logic [3:0] BR_BANZ = 4'd9;
    localparam logic [3:0] BR_BIOZ = 4'd10;
    localparam logic [3:0] BR_CALL = 4'd11;
    localparam logic [3:0] BR_RET  = 4'd12;
    localparam logic [3:0] BR_PUSH = 4'd13;
    localparam logic [3:0] BR_POP  = 4'd14;
    localparam logic [3:0] BR_CALA = 4'd15;

    typedef enum logic {
        ST_EXEC = 1'b0,
        ST_ADDR = 1'b1
    } seq_state_t;

    // Two-word ops: opcode followed by a branch-address word.
    function automatic logic is_two_word(input logic [3:0] op);
        return (op >= BR_B) && (op <= BR_CALL);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer <-> core bundle: fetch word, decoded flow op, status flags, and PC/stack results.
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 12
);
    logic                stall;
    logic [15:0]         instr;
    logic [3:0]          br_op;
    logic                acc_zero;
    logic                acc_neg;
    logic                acc_ovf;
    logic                ar_nonzero;
    logic                bio_n;
    logic [PC_WIDTH-1:0] acc_low;
    logic [PC_WIDTH-1:0] pc;
    logic                issue_valid;
    logic [PC_WIDTH-1:0] stack_top;
    logic [2:0]          stack_depth;
    logic                stack_err;

    modport master (
        input  stall, instr, br_op, acc_zero, acc_neg, acc_ovf, ar_nonzero, bio_n, acc_low,
        output pc, issue_valid, stack_top, stack_depth, stack_err
    );

    modport slave (
        output stall, instr, br_op, acc_zero, acc_neg, acc_ovf, ar_nonzero, bio_n, acc_low,
        input  pc, issue_valid, stack_top, stack_depth, stack_err
    );
endinterface

// File: rtl/pc_sequencer_stack.sv
// Shift-register return stack: entry 0 is the top; pushes shift down, pops shift up.
// Overflow drops the deepest entry, underflow duplicates it; both set a sticky error.
module pc_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             err
);

    logic [WIDTH-1:0] entries [DEPTH];

    assign top = entries[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else if (push) begin
            for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];
            entries[0] <= push_data;
            if (depth == DW'(DEPTH)) err <= 1'b1;
            else                      depth <= depth + 1'b1;
        end else if (pop) begin
            // Deepest entry is left in place, so it appears duplicated after the shift.
            for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
            if (depth == '0) err <= 1'b1;
            else             depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the PC, the return stack and the two-word branch/call protocol.
// Branches take an opcode cycle plus an address-word cycle (issue_valid low); stall freezes all state.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int PC_STEP     = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    pc_sequencer_if.master    bus
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    seq_state_t          state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                taken_q;
    logic                call_q;
    logic                cond;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                st_push;
    logic                st_pop;
    logic [PC_WIDTH-1:0] st_data;
    logic [PC_WIDTH-1:0] st_top;
    logic [DW-1:0]       st_depth;
    logic                st_err;
    logic                unused_instr_hi;

    assign pc_inc          = pc_q + STEP;
    assign unused_instr_hi = ^bus.instr[15:PC_WIDTH];

    always_comb begin
        cond = 1'b0;
        case (bus.br_op)
            BR_B, BR_CALL: cond = 1'b1;
            BR_BZ:         cond = bus.acc_zero;
            BR_BNZ:        cond = !bus.acc_zero;
            BR_BGZ:        cond = !bus.acc_neg && !bus.acc_zero;
            BR_BGEZ:       cond = !bus.acc_neg;
            BR_BLZ:        cond = bus.acc_neg;
            BR_BLEZ:       cond = bus.acc_neg || bus.acc_zero;
            BR_BV:         cond = bus.acc_ovf;
            BR_BANZ:       cond = bus.ar_nonzero;
            BR_BIOZ:       cond = !bus.bio_n;
            default:       cond = 1'b0;
        endcase
    end

    always_comb begin
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_data = pc_inc;
        if (!bus.stall) begin
            if (state == ST_EXEC) begin
                case (bus.br_op)
                    BR_RET:  st_pop  = 1'b1;
                    BR_POP:  st_pop  = 1'b1;
                    BR_CALA: st_push = 1'b1;
                    BR_PUSH: begin
                        st_push = 1'b1;
                        st_data = bus.acc_low;
                    end
                    default: ;
                endcase
            end else begin
                // pc is the address word here, so pc+step is the return address.
                st_push = taken_q && call_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_EXEC;
            pc_q    <= '0;
            taken_q <= 1'b0;
            call_q  <= 1'b0;
        end else if (!bus.stall) begin
            case (state)
                ST_EXEC: begin
                    if (is_two_word(bus.br_op)) begin
                        taken_q <= cond;
                        call_q  <= (bus.br_op == BR_CALL);
                        pc_q    <= pc_inc;
                        state   <= ST_ADDR;
                    end else begin
                        case (bus.br_op)
                            BR_RET:  pc_q <= st_top;
                            BR_CALA: pc_q <= bus.acc_low;
                            default: pc_q <= pc_inc;
                        endcase
                    end
                end
                ST_ADDR: begin
                    pc_q  <= taken_q ? bus.instr[PC_WIDTH-1:0] : pc_inc;
                    state <= ST_EXEC;
                end
                default: state <= ST_EXEC;
            endcase
        end
    end

    pc_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH),
        .DW    (DW)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (st_push),
        .pop       (st_pop),
        .push_data (st_data),
        .top       (st_top),
        .depth     (st_depth),
        .err       (st_err)
    );

    assign bus.pc          = pc_q;
    assign bus.issue_valid = (state == ST_EXEC) && !bus.stall;
    assign bus.stack_top   = st_top;
    assign bus.stack_depth = 3'(st_depth);
    assign bus.stack_err   = st_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed flow scenarios, then random ops checked against a queue-based model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_WIDTH(12)) bus ();

    pc_sequencer #(.PC_WIDTH(12), .STACK_DEPTH(4), .PC_STEP(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: fetch address, "expecting address word" flag, physical stack contents.
    int         m_pc;
    bit         m_addr;
    bit         m_taken;
    bit         m_call;
    logic [11:0] mq[$];
    int         m_depth;
    bit         m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_addr = 0; m_taken = 0; m_call = 0;
        mq = '{12'h0, 12'h0, 12'h0, 12'h0};
        m_depth = 0; m_err = 0;
    endtask

    task automatic m_push(input logic [11:0] v);
        mq.push_front(v);
        void'(mq.pop_back());
        if (m_depth == 4) m_err = 1; else m_depth++;
    endtask

    task automatic m_pop();
        void'(mq.pop_front());
        mq.push_back(mq[$]);
        if (m_depth == 0) m_err = 1; else m_depth--;
    endtask

    function automatic bit m_cond(input int op);
        case (op)
            1, 11: return 1;
            2:  return bus.acc_zero;
            3:  return !bus.acc_zero;
            4:  return !bus.acc_neg && !bus.acc_zero;
            5:  return !bus.acc_neg;
            6:  return bus.acc_neg;
            7:  return bus.acc_neg || bus.acc_zero;
            8:  return bus.acc_ovf;
            9:  return bus.ar_nonzero;
            10: return !bus.bio_n;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int op;
        op = int'(bus.br_op);
        if (bus.stall) return;
        if (m_addr) begin
            if (m_taken) begin
                if (m_call) m_push(12'((m_pc + 2) % 4096));
                m_pc = int'(bus.instr[11:0]);
            end else begin
                m_pc = (m_pc + 2) % 4096;
            end
            m_addr = 0;
        end else if (op >= 1 && op <= 11) begin
            m_taken = m_cond(op);
            m_call  = (op == 11);
            m_pc    = (m_pc + 2) % 4096;
            m_addr  = 1;
        end else begin
            case (op)
                12: begin m_pc = int'(mq[0]); m_pop(); end
                13: begin m_push(bus.acc_low); m_pc = (m_pc + 2) % 4096; end
                14: begin m_pop(); m_pc = (m_pc + 2) % 4096; end
                15: begin m_push(12'((m_pc + 2) % 4096)); m_pc = int'(bus.acc_low); end
                default: m_pc = (m_pc + 2) % 4096;
            endcase
        end
    endtask

    // One clock: apply inputs at the falling edge, compare, advance model and DUT on the rising edge.
    task automatic cyc(input logic [3:0] op, input logic [15:0] w, input logic st);
        bus.br_op = op;
        bus.instr = w;
        bus.stall = st;
        #1;
        check("pc", 32'(bus.pc), 32'(m_pc));
        check("issue_valid", 32'(bus.issue_valid), 32'(!m_addr && !st));
        check("stack_top", 32'(bus.stack_top), 32'(mq[0]));
        check("stack_depth", 32'(bus.stack_depth), 32'(m_depth));
        check("stack_err", 32'(bus.stack_err), 32'(m_err));
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_depth", 32'(bus.stack_depth), 32'h0);
        check("rst_err", 32'(bus.stack_err), 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic jump_to(input logic [11:0] a);
        cyc(BR_B, 16'h0, 1'b0);
        cyc(BR_NONE, {4'h0, a}, 1'b0);
    endtask

    logic [11:0] ret_exp [5];

    initial begin
        bus.stall = 0; bus.instr = '0; bus.br_op = BR_NONE;
        bus.acc_zero = 0; bus.acc_neg = 0; bus.acc_ovf = 0;
        bus.ar_nonzero = 0; bus.bio_n = 1; bus.acc_low = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_iv", 32'(bus.issue_valid), 32'h1);

        for (int i = 0; i < 4; i++) begin
            check("none_pc", 32'(bus.pc), 32'(i * 2));
            cyc(BR_NONE, 16'h0, 1'b0);
        end

        jump_to(12'h010);
        bus.acc_zero = 1;
        check("bz_pc0", 32'(bus.pc), 32'h010);
        cyc(BR_BZ, 16'h0, 1'b0);
        check("bz_pc1", 32'(bus.pc), 32'h012);
        check("bz_bubble", 32'(bus.issue_valid), 32'h0);
        cyc(BR_NONE, 16'h0100, 1'b0);
        check("bz_target", 32'(bus.pc), 32'h100);

        jump_to(12'h010);
        cyc(BR_BNZ, 16'h0, 1'b0);
        check("bnz_pc1", 32'(bus.pc), 32'h012);
        check("bnz_bubble", 32'(bus.issue_valid), 32'h0);
        bus.acc_zero = 0;
        cyc(BR_RET, 16'h0100, 1'b0);
        check("bnz_fall", 32'(bus.pc), 32'h014);

        jump_to(12'h020);
        cyc(BR_CALL, 16'h0, 1'b0);
        cyc(BR_NONE, 16'h0200, 1'b0);
        check("call_pc", 32'(bus.pc), 32'h200);
        check("call_top", 32'(bus.stack_top), 32'h024);
        check("call_depth", 32'(bus.stack_depth), 32'h1);
        cyc(BR_RET, 16'h0, 1'b0);
        check("ret_pc", 32'(bus.pc), 32'h024);
        check("ret_depth", 32'(bus.stack_depth), 32'h0);
        check("ret_err", 32'(bus.stack_err), 32'h0);

        @(negedge clk);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(BR_CALL, 16'h0, 1'b0);
            cyc(BR_PUSH, 16'((k + 1) * 16'h100), 1'b0);
        end
        check("ovf_err", 32'(bus.stack_err), 32'h1);
        check("ovf_depth", 32'(bus.stack_depth), 32'h4);
        ret_exp = '{12'h404, 12'h304, 12'h204, 12'h104, 12'h104};
        for (int k = 0; k < 5; k++) begin
            cyc(BR_RET, 16'h0, 1'b0);
            check("ovf_ret_pc", 32'(bus.pc), 32'(ret_exp[k]));
        end
        check("unf_depth", 32'(bus.stack_depth), 32'h0);

        @(negedge clk);
        do_reset();
        cyc(BR_B, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(BR_NONE, 16'h0300, 1'b1);
            check("stall_pc", 32'(bus.pc), 32'h002);
        end
        cyc(BR_NONE, 16'h0300, 1'b0);
        check("stall_target", 32'(bus.pc), 32'h300);

        cyc(BR_CALL, 16'h0, 1'b0);
        check("mid_addr_pc", 32'(bus.pc), 32'h302);
        bus.br_op = BR_NONE;
        do_reset();
        check("mid_iv", 32'(bus.issue_valid), 32'h1);
        cyc(BR_NONE, 16'h0300, 1'b0);
        check("mid_discard", 32'(bus.pc), 32'h002);

        for (int i = 0; i < 3000; i++) begin
            bus.acc_zero   = 1'($urandom);
            bus.acc_neg    = 1'($urandom);
            bus.acc_ovf    = 1'($urandom);
            bus.ar_nonzero = 1'($urandom);
            bus.bio_n      = 1'($urandom);
            bus.acc_low    = 12'($urandom);
            cyc(4'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the DSP core. It replaces the free-running PC register and PC input mux with a sequencer that owns the program counter, the 4-deep hardware return stack and the two-word branch/call protocol. It evaluates branch conditions from accumulator/AR/BIO status, flags the cycle that carries a branch-address word so the LUT/decoder ignore it, and exposes the stack top to the accumulator input mux (POP) and the PC to instruction memory.

## Interface
- PC_WIDTH, 12, program-counter and stack-entry width
- STACK_DEPTH, 4, return-stack entries
- PC_STEP, 2, PC increment per instruction word

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle
- instr  in  16  word read from instruction memory at `pc` (combinational read, same cycle)
- br_op  in  4  decoded flow op of current word (encoding in package)
- acc_zero, acc_neg, acc_ovf  in  1 each  accumulator status, current cycle
- ar_nonzero  in  1  selected AR != 0
- bio_n  in  1  BIO pin, active low
- acc_low  in  PC_WIDTH  accumulator[11:0] for PUSH/CALA
- pc  out  PC_WIDTH  current fetch address
- issue_valid  out  1  current word is an opcode to execute
- stack_top  out  PC_WIDTH  stack entry 0 (combinational)
- stack_depth  out  3  occupied entries, 0..STACK_DEPTH
- stack_err  out  1  sticky overflow/underflow

## Operation
- br_op: 0 NONE, 1 B, 2 BZ, 3 BNZ, 4 BGZ, 5 BGEZ, 6 BLZ, 7 BLEZ, 8 BV, 9 BANZ, 10 BIOZ, 11 CALL, 12 RET, 13 PUSH, 14 POP, 15 CALA.
- Conditions: B/CALL always; BZ acc_zero; BNZ !acc_zero; BGZ !acc_neg&!acc_zero; BGEZ !acc_neg; BLZ acc_neg; BLEZ acc_neg|acc_zero; BV acc_ovf; BANZ ar_nonzero; BIOZ !bio_n.
- FSM states EXEC, ADDR. issue_valid = (state==EXEC) & !stall.
- EXEC, br_op 1..11: latch taken, latch is_call; pc <= pc+PC_STEP; go ADDR.
- ADDR: instr is target word. taken: pc <= instr[PC_WIDTH-1:0], CALL also pushes pc+PC_STEP; not taken: pc <= pc+PC_STEP. Return to EXEC.
- EXEC RET: pc <= stack_top, pop. CALA: push pc+PC_STEP, pc <= acc_low. PUSH: push acc_low, pc+PC_STEP. POP: pop (stack_top valid for accumulator load this cycle), pc+PC_STEP. NONE: pc+PC_STEP.
- PC arithmetic modulo 2^PC_WIDTH; wrap 0xFFE -> 0x000 silent.
- Push: entries shift down, new value at entry 0; push at full discards deepest entry, depth stays STACK_DEPTH, stack_err <= 1.
- Pop: entries shift up, deepest entry duplicated; pop at depth 0 leaves entries, stack_err <= 1, RET still loads stack_top.
- stack_err cleared only by reset.

## Timing
- Reset (async assert, sync-to-clk release): pc 0, state EXEC, all entries 0, stack_depth 0, stack_err 0, issue_valid 1 (if !stall).
- Non-branch: 1 cycle/word. Branch/CALL: 2 cycles (opcode + address word); one bubble (issue_valid 0) in ADDR. RET/CALA/PUSH/POP: 1 cycle.
- Condition sampled in EXEC cycle of opcode only; flag changes in ADDR ignored.
- stall=1: pc, state, latches, stack frozen; stall beats any br_op.
- Reset during ADDR: target discarded, pending CALL push lost.
- br_op ignored in ADDR.

## Structure
- Package pc_seq_pkg: br_op localparams, FSM state encoding, default widths.
- Sub-module pc_stack: parameterised shift LIFO (push, pop, push_data, top, depth, err).
- Top holds FSM, condition mux, PC next-state mux.

## Test plan
- Reset then 4 NONE cycles -> pc 0x000,0x002,0x004,0x006; issue_valid 1 throughout.
- BZ at 0x010, acc_zero=1, next word 0x0100 -> pc 0x010, 0x012 (issue_valid 0), 0x100.
- BNZ at 0x010, acc_zero=1 -> pc 0x010, 0x012 (issue_valid 0), 0x014.
- CALL at 0x020 target 0x200, RET at 0x200 -> stack_top 0x024, depth 1; after RET pc 0x024, depth 0, stack_err 0.
- Five CALLs -> fifth sets stack_err, depth 4, first return address lost; four RETs return newest first; fifth RET leaves pc = duplicated deepest entry.
- stall held 3 cycles in ADDR -> pc frozen; then target loaded. reset_n low mid-ADDR -> pc 0, EXEC immediately, no clk needed.
